// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RISC-V control unit sequencing one ALU and one memory port.
// Optional macro ILLEGAL_TRAP_EN makes unknown opcodes trap into a sticky TRAP state.
module mc_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_op1,
  output logic             alu_op0,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
                         MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXEC_R = 4'd6, R_WB = 4'd7,
                         BRANCH = 4'd8, TRAP = 4'd9;
  localparam logic [6:0] OP_R = 7'b0110011, OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_BEQ = 7'b1100011;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] ILL_NEXT = TRAP, TRAP_NEXT = TRAP;
`else
  localparam logic [3:0] ILL_NEXT = FETCH, TRAP_NEXT = FETCH;
`endif
  logic [3:0]       st, nx;
  logic [CNT_W-1:0] cnt;
  logic [13:0]      ctrl;
  logic             retire;
  logic             unused;
  // zero only matters to the datapath, which ANDs it with pc_write_cond
  assign unused = zero;
  assign retire = (st == MEM_WB) || (st == R_WB) || (st == BRANCH) ||
                  (st == MEM_WRITE && mem_ready);
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st <= nx;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end
`ifdef ILLEGAL_TRAP_EN
  logic ill;
  always_ff @(posedge clk) begin
    if (reset) ill <= 1'b0;
    else if (nx == TRAP) ill <= 1'b1;
  end
  assign illegal = reset ? 1'b0 : ill;
`else
  assign illegal = 1'b0;
`endif
  always_comb begin
    nx = FETCH;
    case (st)
      FETCH:     nx = mem_ready ? DECODE : FETCH;
      DECODE:    nx = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                      (opcode == OP_R) ? EXEC_R : (opcode == OP_BEQ) ? BRANCH : ILL_NEXT;
      MEM_ADDR:  nx = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:  nx = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nx = mem_ready ? FETCH : MEM_WRITE;
      EXEC_R:    nx = R_WB;
      TRAP:      nx = TRAP_NEXT;
      default:   nx = FETCH;
    endcase
  end
  // bit order: pc_write pc_write_cond pc_source i_or_d mem_read mem_write ir_write
  //            mem_to_reg reg_write alu_src_a alu_src_b[1:0] alu_op1 alu_op0
  always_comb begin
    ctrl = '0;
    if (!reset)
      case (st)
        FETCH:     ctrl = mem_ready ? 14'b10001010000100 : 14'b00001000000100;
        DECODE:    ctrl = 14'b00000000001000;
        MEM_ADDR:  ctrl = 14'b00000000011000;
        MEM_READ:  ctrl = 14'b00011000000000;
        MEM_WB:    ctrl = 14'b00000001100000;
        MEM_WRITE: ctrl = 14'b00010100000000;
        EXEC_R:    ctrl = 14'b00000000010010;
        R_WB:      ctrl = 14'b00000000100000;
        BRANCH:    ctrl = 14'b01100000010001;
        default:   ctrl = '0;
      endcase
  end
  assign {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
          mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op1, alu_op0} = ctrl;
  assign state       = reset ? 4'd0 : st;
  assign instr_count = reset ? '0 : cnt;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed scoreboard bench; a 2-bit-counter twin instance exercises counter wrap.
module tb_mc_control_fsm;
  localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011, BQ = 7'b1100011,
                         BAD = 7'b1111111;
  localparam logic [13:0] F_RDY = 14'b10001010000100, F_WAIT = 14'b00001000000100,
                          DEC = 14'b00000000001000, MA = 14'b00000000011000,
                          MRD = 14'b00011000000000, MWB = 14'b00000001100000,
                          MWR = 14'b00010100000000, EXR = 14'b00000000010010,
                          RWB = 14'b00000000100000, BR = 14'b01100000010001, NONE = 14'b0;
  typedef struct packed {
    logic [13:0] ctrl;
    logic [3:0]  st;
    logic [15:0] cnt;
    logic        ill;
    logic [1:0]  scnt;
    logic [7:0]  tag;
  } exp_t;
  logic clk = 1'b1, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
        mem_to_reg, reg_write, alu_src_a, alu_op1, alu_op0, illegal;
  logic [1:0] alu_src_b;
  logic [3:0] state;
  logic [15:0] instr_count;
  logic w_pw, w_pwc, w_ps, w_iod, w_mr, w_mw, w_irw, w_m2r, w_rw, w_sa, w_o1, w_o0, w_ill;
  logic [1:0] w_sb, w_cnt;
  logic [3:0] w_state;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  logic [7:0] tag = 0;
  always #5 clk = ~clk;
  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op1(alu_op1), .alu_op0(alu_op0), .state(state),
    .instr_count(instr_count), .illegal(illegal));
  mc_control_fsm #(.CNT_W(2)) u_w (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(w_pw), .pc_write_cond(w_pwc), .pc_source(w_ps), .i_or_d(w_iod),
    .mem_read(w_mr), .mem_write(w_mw), .ir_write(w_irw), .mem_to_reg(w_m2r),
    .reg_write(w_rw), .alu_src_a(w_sa), .alu_src_b(w_sb), .alu_op1(w_o1), .alu_op0(w_o0),
    .state(w_state), .instr_count(w_cnt), .illegal(w_ill));
  // one expected vector per cycle; the monitor consumes it mid-cycle
  task automatic step(input logic rst, input logic [6:0] op, input logic mr, input logic z,
                      input logic [13:0] c, input logic [3:0] s, input logic [15:0] n,
                      input logic il);
    reset = rst; opcode = op; mem_ready = mr; zero = z;
    q.push_back('{ctrl: c, st: s, cnt: n, ill: il, scnt: n[1:0], tag: tag});
    tag = tag + 8'd1;
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [13:0] a, w;
      e = q.pop_front();
      a = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op1, alu_op0};
      w = {w_pw, w_pwc, w_ps, w_iod, w_mr, w_mw, w_irw, w_m2r, w_rw, w_sa, w_sb, w_o1, w_o0};
      compared++;
      if (a !== e.ctrl || state !== e.st || instr_count !== e.cnt || illegal !== e.ill ||
          w !== e.ctrl || w_state !== e.st || w_cnt !== e.scnt || w_ill !== e.ill) begin
        mismatched++;
        $display("FAIL cycle%0d: got ctrl=%b st=%0d cnt=%0d ill=%b twin ctrl=%b st=%0d cnt=%0d ill=%b; want ctrl=%b st=%0d cnt=%0d ill=%b twin cnt=%0d",
                 e.tag, a, state, instr_count, illegal, w, w_state, w_cnt, w_ill,
                 e.ctrl, e.st, e.cnt, e.ill, e.scnt);
      end
    end
  end
  initial begin
    step(1, 0, 1, 0, NONE, 0, 0, 0);
    step(1, 0, 1, 0, NONE, 0, 0, 0);
    step(0, R, 0, 0, F_WAIT, 0, 0, 0);
    step(0, R, 1, 0, F_RDY, 0, 0, 0);
    step(0, R, 1, 0, DEC, 1, 0, 0);
    step(0, R, 1, 0, EXR, 6, 0, 0);
    step(0, R, 1, 0, RWB, 7, 0, 0);
    step(0, LW, 1, 0, F_RDY, 0, 1, 0);
    step(0, LW, 0, 0, DEC, 1, 1, 0);
    step(0, LW, 0, 0, MA, 2, 1, 0);
    step(0, LW, 0, 0, MRD, 3, 1, 0);
    step(0, LW, 0, 0, MRD, 3, 1, 0);
    step(0, LW, 0, 0, MRD, 3, 1, 0);
    step(0, LW, 1, 0, MRD, 3, 1, 0);
    step(0, LW, 0, 0, MWB, 4, 1, 0);
    step(0, SW, 1, 0, F_RDY, 0, 2, 0);
    step(0, SW, 1, 0, DEC, 1, 2, 0);
    step(0, SW, 1, 0, MA, 2, 2, 0);
    step(0, SW, 1, 0, MWR, 5, 2, 0);
    step(0, BQ, 1, 1, F_RDY, 0, 3, 0);
    step(0, BQ, 1, 1, DEC, 1, 3, 0);
    step(0, BQ, 1, 1, BR, 8, 3, 0);
    step(0, BAD, 1, 0, F_RDY, 0, 4, 0);
    step(0, BAD, 1, 0, DEC, 1, 4, 0);
`ifdef ILLEGAL_TRAP_EN
    step(0, BAD, 1, 0, NONE, 9, 4, 1);
    step(0, R, 1, 0, NONE, 9, 4, 1);
    step(0, R, 1, 0, NONE, 9, 4, 1);
`else
    step(0, R, 0, 0, F_WAIT, 0, 4, 0);
    step(0, R, 1, 0, F_RDY, 0, 4, 0);
    step(0, R, 1, 0, DEC, 1, 4, 0);
`endif
    step(1, SW, 1, 0, NONE, 0, 0, 0);
    step(0, SW, 1, 0, F_RDY, 0, 0, 0);
    step(0, SW, 1, 0, DEC, 1, 0, 0);
    step(0, SW, 0, 0, MA, 2, 0, 0);
    step(0, SW, 0, 0, MWR, 5, 0, 0);
    step(1, SW, 0, 0, NONE, 0, 0, 0);
    step(0, SW, 0, 0, F_WAIT, 0, 0, 0);
    @(negedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
